// File: rtl/tick_rate_controller_pkg.sv
// tick_rate_controller_pkg
// Shared definitions for the slow-clock divider controller and the
// sequencers that consume its tick (display refresh, memory sequencing).
//   state_t          : FSM state encoding (IDLE/LOW/HIGH, 2 bits)
//   TRC_CNT_W        : default width of the half-period counter
//   TRC_DEFAULT_HALF : half-period loaded at reset, in CLK100MHZ cycles
package tick_rate_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam int TRC_CNT_W        = 10;
    localparam int TRC_DEFAULT_HALF = 500;

endpackage

// File: rtl/tick_rate_controller_half_period_counter.sv
// tick_rate_controller_half_period_counter
// Counts cycles within one slow_clk phase and flags the last cycle.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   en       : advance the count this cycle
//   clr      : force the count to zero (takes priority over en)
//   limit    : phase length in cycles (>= 1); terminal count is limit-1
//   done     : high on the last cycle of the phase while enabled
module tick_rate_controller_half_period_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] term;

    // limit is never 0, so limit-1 cannot underflow.
    assign term = limit - CNT_W'(1);
    assign done = en && (count == term);

    // The count wraps to zero on done, so it never exceeds limit-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (done) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tick_rate_controller.sv
// tick_rate_controller
// Generates the divided slow_clk square wave and a one-cycle tick strobe,
// with run/stop control and half-period updates that only land on a
// period boundary.
// Ports:
//   CLK100MHZ   : system clock, rising edge
//   reset       : asynchronous active-high reset
//   run         : 1 = keep generating periods, 0 = stop after current period
//   cfg_valid   : cfg_half holds a new half-period
//   cfg_half    : requested half-period (0 is treated as 1)
//   cfg_ready   : a configuration can be accepted this cycle
//   slow_clk    : divided clock, active_half low then active_half high
//   tick        : one-cycle pulse on the cycle slow_clk rises
//   active_half : half-period currently in effect
//   running     : high whenever the FSM is not idle
//   fsm_state   : current FSM state, for debug/observation
//
// Handshake: a configuration transfers on any rising edge where
// cfg_valid && cfg_ready; the source holds cfg_half stable until then,
// and cfg_valid while cfg_ready is low has no effect.
module tick_rate_controller
    import tick_rate_controller_pkg::*;
#(
    parameter int CNT_W        = TRC_CNT_W,
    parameter int DEFAULT_HALF = TRC_DEFAULT_HALF
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             slow_clk,
    output logic             tick,
    output logic [CNT_W-1:0] active_half,
    output logic             running,
    output state_t           fsm_state
);

    state_t           state;
    logic [CNT_W-1:0] pend_half;
    logic             pending;
    logic             xfer;
    logic             cnt_en;
    logic             cnt_clr;
    logic             phase_done;
    logic [CNT_W-1:0] cfg_half_clamped;

    // Only one update may be outstanding at a time.
    assign cfg_ready        = !pending;
    assign xfer             = cfg_valid && cfg_ready;
    assign cfg_half_clamped = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

    assign cnt_en    = (state == LOW) || (state == HIGH);
    assign cnt_clr   = !cnt_en;
    assign running   = (state != IDLE);
    assign fsm_state = state;

    tick_rate_controller_half_period_counter #(
        .CNT_W (CNT_W)
    ) u_half_period_counter (
        .clk   (CLK100MHZ),
        .rst   (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .limit (active_half),
        .done  (phase_done)
    );

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            slow_clk    <= 1'b0;
            tick        <= 1'b0;
            active_half <= CNT_W'(DEFAULT_HALF);
            pend_half   <= '0;
            pending     <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                IDLE: begin
                    slow_clk <= 1'b0;
                    // Nothing is in flight, so the new value is safe to use now.
                    if (xfer) begin
                        active_half <= cfg_half_clamped;
                    end
                    if (run) begin
                        state <= LOW;
                    end
                end
                LOW: begin
                    if (phase_done) begin
                        slow_clk <= 1'b1;
                        tick     <= 1'b1;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_done) begin
                        slow_clk <= 1'b0;
                        if (pending) begin
                            active_half <= pend_half;
                            pending     <= 1'b0;
                        end
                        state <= run ? LOW : IDLE;
                    end
                end
                default: begin
                    slow_clk <= 1'b0;
                    state    <= IDLE;
                end
            endcase

            // While a period is in progress, park the value until the next
            // HIGH->LOW boundary. A transfer can only occur with pending=0,
            // so this never collides with the apply above; a transfer on the
            // boundary cycle therefore waits for the following boundary.
            if (xfer && (state == LOW || state == HIGH)) begin
                pend_half <= cfg_half_clamped;
                pending   <= 1'b1;
            end
        end
    end

endmodule
